// File: rtl/sipo_frame_tx_if.sv
// Parallel-in / framed-serial-out link bundle for sipo_frame_tx.
// master = word producer and line observer, slave = the transmitter.
interface sipo_frame_tx_if #(
  parameter int PAYLOAD_BITS = 5
);
  logic [PAYLOAD_BITS-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    d_out;
  logic                    frame_sync;
  logic                    tx_busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, d_out, frame_sync, tx_busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, d_out, frame_sync, tx_busy
  );
endinterface

// File: rtl/sipo_frame_tx.sv
// Framed serial transmitter: one buffered word per FRAME_LEN-cycle frame, LSB first.
// Optional even-parity bit in slot PAYLOAD_BITS when SIPO_FRAME_TX_PARITY_EN is defined.
module sipo_frame_tx #(
  parameter int PAYLOAD_BITS = 5,
  parameter int FRAME_LEN    = 8
) (
  input  logic           clock,
  input  logic           reset,
  sipo_frame_tx_if.slave bus
);
  localparam int             CW   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  NPAY = CW'(PAYLOAD_BITS);

  logic [CW-1:0]           count_q, count_d;
  logic [PAYLOAD_BITS-1:0] buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic                    busy_q, busy_d;
  logic                    accept;
  logic                    pay_slot;
`ifdef SIPO_FRAME_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  assign accept   = bus.in_valid && !buf_full_q;
  assign pay_slot = (count_q < NPAY);

  always_comb begin
    count_d    = count_q + CW'(1);
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
`ifdef SIPO_FRAME_TX_PARITY_EN
    par_d      = par_q;
`endif
    if (count_q == LAST) begin
      // Frame boundary: buffered word wins; an empty buffer lets a new word bypass.
      if (buf_full_q) begin
        shreg_d    = buf_q;
        busy_d     = 1'b1;
        buf_full_d = 1'b0;
`ifdef SIPO_FRAME_TX_PARITY_EN
        par_d      = ^buf_q;
`endif
      end else if (accept) begin
        shreg_d = bus.in_data;
        busy_d  = 1'b1;
`ifdef SIPO_FRAME_TX_PARITY_EN
        par_d   = ^bus.in_data;
`endif
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      if (busy_q && pay_slot)
        shreg_d = shreg_q >> 1;
      if (accept) begin
        buf_d      = bus.in_data;
        buf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
`ifdef SIPO_FRAME_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      busy_q     <= busy_d;
`ifdef SIPO_FRAME_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Outputs decode registers only; busy_q clears on reset so d_out drops at once.
`ifdef SIPO_FRAME_TX_PARITY_EN
  assign bus.d_out = busy_q && ((pay_slot && shreg_q[0]) || (count_q == NPAY && par_q));
`else
  assign bus.d_out = busy_q && pay_slot && shreg_q[0];
`endif
  assign bus.tx_busy    = busy_q;
  assign bus.in_ready   = !buf_full_q;
  assign bus.frame_sync = (count_q == '0);
endmodule

// File: tb/tb_sipo_frame_tx.sv
// Randomised + directed bench for sipo_frame_tx with a frame-level reference model.
module tb_sipo_frame_tx;
  localparam int P = 5;
  localparam int F = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sipo_frame_tx_if #(.PAYLOAD_BITS(P)) bus ();

  sipo_frame_tx #(.PAYLOAD_BITS(P), .FRAME_LEN(F)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic d;
    logic busy;
    logic sync;
    logic rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: slot of the current cycle, words waiting, word of current frame.
  int           m_slot = 0;
  logic [P-1:0] m_wait[$];
  logic [P-1:0] m_cur = '0;
  bit           m_busy = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic exp_line(input int slot, input bit busy, input logic [P-1:0] w);
    if (!busy) return 1'b0;
    if (slot < P) return w[slot];
`ifdef SIPO_FRAME_TX_PARITY_EN
    if (slot == P) return ^w;
`endif
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    bit   acc;
    exp_t e;
    if (!reset) begin
      acc = bus.in_valid && (m_wait.size() == 0);
      if (m_slot == F - 1) begin
        if (m_wait.size() > 0) begin
          m_cur  = m_wait.pop_front();
          m_busy = 1;
        end else if (acc) begin
          m_cur  = bus.in_data;
          m_busy = 1;
        end else begin
          m_busy = 0;
        end
      end else if (acc) begin
        m_wait.push_back(bus.in_data);
      end
      m_slot = (m_slot + 1) % F;
      e.sync = (m_slot == 0);
      e.busy = m_busy;
      e.rdy  = (m_wait.size() == 0);
      e.d    = exp_line(m_slot, m_busy, m_cur);
      sb.push_back(e);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      check("d_out", bus.d_out, e.d);
      check("tx_busy", bus.tx_busy, e.busy);
      check("frame_sync", bus.frame_sync, e.sync);
      check("in_ready", bus.in_ready, e.rdy);
    end
  end

  // Leaves the caller at the negedge inside slot k.
  task automatic goto_slot(input int k);
    for (int i = 0; i <= F; i++) begin
      @(negedge clock);
      if (m_slot == k) return;
    end
    checks++;
    errors++;
    $display("FAIL goto_slot: slot %0d not reached, at %0d", k, m_slot);
  endtask

  task automatic send_at(input logic [P-1:0] w, input int k);
    goto_slot(k);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous reset values.
  task automatic do_reset();
    #2 reset = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    m_wait.delete();
    m_slot = 0;
    m_busy = 0;
    #1;
    check("rst_d_out", bus.d_out, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_tx_busy", bus.tx_busy, 1'b0);
    check("rst_frame_sync", bus.frame_sync, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check("rst_d_out", bus.d_out, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_tx_busy", bus.tx_busy, 1'b0);
    check("rst_frame_sync", bus.frame_sync, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(10);

    send_at(5'b10110, 2);
    idle(20);

    // Back-to-back: first word bypasses at slot 7, second buffers in slot 0.
    goto_slot(F - 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 5'b00001;
    @(negedge clock);
    bus.in_data  = 5'b11111;
    @(negedge clock);
    bus.in_valid = 1'b0;
    idle(24);

    send_at(5'b01010, F - 1);
    idle(16);

    // Reset in slot 2 of a busy frame carrying all ones.
    send_at(5'b11111, F - 1);
    goto_slot(2);
    do_reset();
    idle(20);

    // Stall: valid held high with fresh data each cycle for several frames.
    goto_slot(3);
    for (int i = 0; i < 4 * F + 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = P'($urandom);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    idle(20);

    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_data  = P'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else @(negedge clock);
    end
    bus.in_valid = 1'b0;
    idle(2 * F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
